// File: rtl/picorv32_sram_bridge.sv
// Bridge from the picorv32 native memory bus to NUM_BANKS single-port SRAM macros.
// Latency: write/error response 1 cycle after acceptance, read 1+READ_LATENCY cycles.
// Backpressure: one transfer in flight; mem_valid is only sampled in IDLE, core waits for mem_ready.
module picorv32_sram_bridge #(
  parameter int          NUM_BANKS      = 2,
  parameter int          BANK_ADDR_BITS = 9,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          READ_LATENCY   = 1,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic                      mem_instr,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_wstrb,
  output logic                      mem_ready,
  output logic [31:0]               mem_rdata,
  output logic [NUM_BANKS-1:0]      sram_csb,
  output logic                      sram_web,
  output logic [3:0]                sram_wmask,
  output logic [BANK_ADDR_BITS-1:0] sram_addr,
  output logic [31:0]               sram_din,
  input  logic [32*NUM_BANKS-1:0]   sram_dout,
  output logic                      bus_err,
  output logic                      err_instr,
  output logic [15:0]               err_count
);

  localparam int BANK_SEL_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W        = (BANK_SEL_BITS > 0) ? BANK_SEL_BITS : 1;
  // Lowest byte-address bit that is compared against BASE_ADDR.
  localparam int WIN_LSB       = 2 + BANK_ADDR_BITS + BANK_SEL_BITS;
  localparam logic [31:0]          WIN_MASK = ~((32'd1 << WIN_LSB) - 32'd1);
  localparam logic [1:0]           LAT_INIT = 2'(READ_LATENCY - 1);
  localparam logic [NUM_BANKS-1:0] BANK_ONE = NUM_BANKS'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  logic [1:0]        state;
  logic [1:0]        lat_cnt;
  logic [BANK_W-1:0] req_bank;
  logic [BANK_W-1:0] bank_q;
  logic              in_window;
  logic              is_write;
  logic              accept;
  logic              hit;
  logic [31:0]       rd_word;

  assign in_window = ((mem_addr ^ BASE_ADDR) & WIN_MASK) == 32'd0;
  assign is_write  = |mem_wstrb;
  // Reset gating keeps every macro deselected while reset is held, even with mem_valid high.
  assign accept    = (state == IDLE) && mem_valid && !reset;
  assign hit       = accept && in_window;

  generate
    if (BANK_SEL_BITS == 0) begin : g_single_bank
      assign req_bank = '0;
    end else begin : g_multi_bank
      assign req_bank = mem_addr[2+BANK_ADDR_BITS +: BANK_W];
    end
  endgenerate

  assign sram_addr = mem_addr[2 +: BANK_ADDR_BITS];
  assign sram_din  = mem_wdata;
  assign rd_word   = sram_dout[32*int'(bank_q) +: 32];
  assign mem_ready = (state == RESP);

  // Macro strobes are purely combinational from the request on the accepting IDLE cycle.
  always_comb begin
    sram_csb   = '1;
    sram_web   = 1'b1;
    sram_wmask = 4'h0;
    if (hit) begin
      sram_csb   = ~(BANK_ONE << req_bank);
      sram_web   = ~is_write;
      sram_wmask = mem_wstrb;
    end
  end

  // Transfer FSM, read-latency counter, response data and error bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= 2'd0;
      bank_q    <= '0;
      mem_rdata <= 32'd0;
      bus_err   <= 1'b0;
      err_instr <= 1'b0;
      err_count <= 16'd0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_window) begin
              if (is_write) begin
                state <= RESP;
              end else begin
                bank_q  <= req_bank;
                lat_cnt <= LAT_INIT;
                state   <= RD_WAIT;
              end
            end else begin
              // Writes outside the window leave the last read data untouched.
              if (!is_write) begin
                mem_rdata <= ERR_RDATA;
              end
              bus_err   <= 1'b1;
              err_instr <= mem_instr;
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
              end
              state <= RESP;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else begin
            mem_rdata <= rd_word;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
